cnn_layer_sequencer: RTL and testbench

//  Central controller for the single-image CNN pipeline (conv 5x5x8 -> relu -> 2x2 maxpool -> fc 1152x10 -> argmax).

---
 rtl/cnn_layer_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer for conv -> relu -> pool -> fc -> argmax: window/address counters, valid pipes, FSM.
// Start to done is 726 cycles counting the start cycle, with fc_done already high; no backpressure, only start/abort/fc_done.
module cnn_layer_sequencer #(
  parameter int CONV_DIM   = 24,
  parameter int POOL_DIM   = 12,
  parameter int CONV_LAT   = 2,
  parameter int POOL_LAT   = 1,
  parameter int FC_TIMEOUT = 4095
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       fc_done_i,
  output logic [4:0] win_x_o,
  output logic [4:0] win_y_o,
  output logic       win_valid_o,
  output logic       relu_we_o,
  output logic [9:0] relu_addr_o,
  output logic [3:0] pool_x_o,
  output logic [3:0] pool_y_o,
  output logic       pool_valid_o,
  output logic       pool_out_valid_o,
  output logic [7:0] pool_idx_o,
  output logic       fc_enable_o,
  output logic       result_load_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_CDRN  = 3'd2;
  localparam logic [2:0] S_POOL  = 3'd3;
  localparam logic [2:0] S_PDRN  = 3'd4;
  localparam logic [2:0] S_FC    = 3'd5;
  localparam logic [2:0] S_RES   = 3'd6;

  localparam int FCW = $clog2(FC_TIMEOUT + 1);
  localparam logic [4:0]     CONV_LAST = 5'(CONV_DIM - 1);
  localparam logic [9:0]     RELU_LAST = 10'(CONV_DIM * CONV_DIM - 1);
  localparam logic [3:0]     POOL_LAST = 4'(POOL_DIM - 1);
  localparam logic [7:0]     PIDX_LAST = 8'(POOL_DIM * POOL_DIM - 1);
  localparam logic [FCW-1:0] FC_LAST   = FCW'(FC_TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic [4:0]          win_x_q, win_x_d, win_y_q, win_y_d;
  logic [3:0]          pool_x_q, pool_x_d, pool_y_q, pool_y_d;
  logic [9:0]          relu_addr_q, relu_addr_d;
  logic [7:0]          pool_idx_q, pool_idx_d;
  logic [FCW-1:0]      fc_cnt_q, fc_cnt_d;
  logic                fc_en_q, fc_en_d;
  logic                error_q, error_d;
  logic [CONV_LAT-1:0] conv_pipe_q, conv_pipe_d;
  logic [POOL_LAT-1:0] pool_pipe_q, pool_pipe_d;

  assign win_valid_o      = (state_q == S_CONV);
  assign pool_valid_o     = (state_q == S_POOL);
  assign relu_we_o        = conv_pipe_q[CONV_LAT-1];
  assign pool_out_valid_o = pool_pipe_q[POOL_LAT-1];
  assign win_x_o          = win_x_q;
  assign win_y_o          = win_y_q;
  assign pool_x_o         = pool_x_q;
  assign pool_y_o         = pool_y_q;
  assign relu_addr_o      = relu_addr_q;
  assign pool_idx_o       = pool_idx_q;
  // fc_enable rises combinationally with the first pooled result, then holds from the register.
  assign fc_enable_o      = fc_en_q | pool_out_valid_o;
  assign result_load_o    = (state_q == S_RES);
  assign done_o           = (state_q == S_RES);
  assign busy_o           = (state_q != S_IDLE);
  assign error_o          = error_q;

  always_comb begin
    state_d     = state_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    pool_x_d    = pool_x_q;
    pool_y_d    = pool_y_q;
    relu_addr_d = relu_addr_q;
    pool_idx_d  = pool_idx_q;
    fc_cnt_d    = fc_cnt_q;
    fc_en_d     = fc_en_q;
    error_d     = error_q;

    conv_pipe_d    = '0;
    conv_pipe_d[0] = win_valid_o;
    for (int i = 1; i < CONV_LAT; i++) conv_pipe_d[i] = conv_pipe_q[i-1];
    pool_pipe_d    = '0;
    pool_pipe_d[0] = pool_valid_o;
    for (int i = 1; i < POOL_LAT; i++) pool_pipe_d[i] = pool_pipe_q[i-1];

    if (relu_we_o && relu_addr_q != RELU_LAST) relu_addr_d = relu_addr_q + 10'd1;
    if (pool_out_valid_o && pool_idx_q != PIDX_LAST) pool_idx_d = pool_idx_q + 8'd1;
    if (pool_out_valid_o) fc_en_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_CONV;
          error_d     = 1'b0;
          relu_addr_d = '0;
          pool_idx_d  = '0;
        end
      end
      S_CONV: begin
        if (win_y_q == CONV_LAST) begin
          win_y_d = '0;
          if (win_x_q == CONV_LAST) begin
            win_x_d = '0;
            state_d = S_CDRN;
          end else begin
            win_x_d = win_x_q + 5'd1;
          end
        end else begin
          win_y_d = win_y_q + 5'd1;
        end
      end
      S_CDRN: if (relu_we_o && relu_addr_q == RELU_LAST) state_d = S_POOL;
      S_POOL: begin
        if (pool_y_q == POOL_LAST) begin
          pool_y_d = '0;
          if (pool_x_q == POOL_LAST) begin
            pool_x_d = '0;
            state_d  = S_PDRN;
          end else begin
            pool_x_d = pool_x_q + 4'd1;
          end
        end else begin
          pool_y_d = pool_y_q + 4'd1;
        end
      end
      S_PDRN: begin
        if (pool_out_valid_o && pool_idx_q == PIDX_LAST) begin
          state_d  = S_FC;
          fc_cnt_d = '0;
        end
      end
      S_FC: begin
        if (fc_done_i) begin
          state_d  = S_RES;
          fc_en_d  = 1'b0;
          fc_cnt_d = '0;
        end else if (fc_cnt_q == FC_LAST) begin
          state_d  = S_IDLE;
          error_d  = 1'b1;
          fc_en_d  = 1'b0;
          fc_cnt_d = '0;
        end else begin
          fc_cnt_d = fc_cnt_q + 1'b1;
        end
      end
      S_RES:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort flushes everything in flight but leaves a recorded timeout visible.
    if (abort_i) begin
      state_d     = S_IDLE;
      win_x_d     = '0;
      win_y_d     = '0;
      pool_x_d    = '0;
      pool_y_d    = '0;
      relu_addr_d = '0;
      pool_idx_d  = '0;
      fc_cnt_d    = '0;
      fc_en_d     = 1'b0;
      conv_pipe_d = '0;
      pool_pipe_d = '0;
      error_d     = error_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      win_x_q     <= '0;
      win_y_q     <= '0;
      pool_x_q    <= '0;
      pool_y_q    <= '0;
      relu_addr_q <= '0;
      pool_idx_q  <= '0;
      fc_cnt_q    <= '0;
      fc_en_q     <= 1'b0;
      error_q     <= 1'b0;
      conv_pipe_q <= '0;
      pool_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      pool_x_q    <= pool_x_d;
      pool_y_q    <= pool_y_d;
      relu_addr_q <= relu_addr_d;
      pool_idx_q  <= pool_idx_d;
      fc_cnt_q    <= fc_cnt_d;
      fc_en_q     <= fc_en_d;
      error_q     <= error_d;
      conv_pipe_q <= conv_pipe_d;
      pool_pipe_q <= pool_pipe_d;
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: cycle 0 is the cycle start is presented; checks are taken 1 time unit after each rising edge.
module tb_cnn_layer_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, fc_done;
  logic [4:0] win_x, win_y;
  logic       win_valid, relu_we, pool_valid, pool_out_valid;
  logic [9:0] relu_addr;
  logic [3:0] pool_x, pool_y;
  logic [7:0] pool_idx;
  logic       fc_enable, result_load, busy, done, error;

  int errors = 0;
  int checks = 0;

  cnn_layer_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .fc_done_i(fc_done),
    .win_x_o(win_x), .win_y_o(win_y), .win_valid_o(win_valid),
    .relu_we_o(relu_we), .relu_addr_o(relu_addr),
    .pool_x_o(pool_x), .pool_y_o(pool_y), .pool_valid_o(pool_valid),
    .pool_out_valid_o(pool_out_valid), .pool_idx_o(pool_idx),
    .fc_enable_o(fc_enable), .result_load_o(result_load),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  logic [44:0] all_outs;
  assign all_outs = {win_valid, relu_we, pool_valid, pool_out_valid, fc_enable, result_load,
                     busy, done, error, win_x, win_y, relu_addr, pool_x, pool_y, pool_idx};

  // Observer statistics, cleared by mon_clr in the start cycle of each run.
  logic mon_clr = 1'b0;
  int cyc, wcnt, first_wcyc, first_wx, first_wy, last_wx, last_wy;
  int rcnt, first_rcyc, prev_rcyc, prev_raddr, addr_err, gap_err;
  int pcnt, pidx_err, dcnt, dcyc, ld_err;

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc = 0; wcnt = 0; first_wcyc = -1; first_wx = -1; first_wy = -1; last_wx = -1; last_wy = -1;
      rcnt = 0; first_rcyc = -1; prev_rcyc = 0; prev_raddr = 0; addr_err = 0; gap_err = 0;
      pcnt = 0; pidx_err = 0; dcnt = 0; dcyc = -1; ld_err = 0;
    end else begin
      cyc++;
    end
    if (win_valid) begin
      if (wcnt == 0) begin first_wcyc = cyc; first_wx = int'(win_x); first_wy = int'(win_y); end
      last_wx = int'(win_x); last_wy = int'(win_y);
      wcnt++;
    end
    if (relu_we) begin
      if (rcnt == 0) begin
        first_rcyc = cyc;
        if (relu_addr != 10'd0) addr_err++;
      end else begin
        if (int'(relu_addr) != prev_raddr + 1) addr_err++;
        if (cyc != prev_rcyc + 1) gap_err++;
      end
      prev_rcyc = cyc; prev_raddr = int'(relu_addr);
      rcnt++;
    end
    if (pool_out_valid) begin
      if (int'(pool_idx) != pcnt) pidx_err++;
      pcnt++;
    end
    if (done) begin
      dcnt++; dcyc = cyc;
      if (!result_load) ld_err++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents start in the current cycle; returns in cycle 1 of the run.
  task automatic start_run();
    start = 1'b1; mon_clr = 1'b1;
    tick();
    start = 1'b0; mon_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fc_done = 1'b1;
    #23;
    chk("reset_outputs_zero", 64'(all_outs), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_fc_done_ignored", 64'(busy), 64'd0);

    // Full run with fc_done tied high; start re-pulsed mid-POOL must be ignored.
    start_run();
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("first_window", 64'({win_valid, win_x, win_y}), 64'({1'b1, 5'd0, 5'd0}));
    for (int i = 2; i <= 730; i++) begin
      tick();
      start = (i == 650);
      if (i == 2)   chk("relu_we_c2", 64'(relu_we), 64'd0);
      if (i == 3)   chk("relu_we_c3", 64'({relu_we, relu_addr}), 64'({1'b1, 10'd0}));
      if (i == 576) chk("last_window", 64'({win_valid, win_x, win_y}), 64'({1'b1, 5'd23, 5'd23}));
      if (i == 578) chk("last_relu", 64'({relu_we, relu_addr}), 64'({1'b1, 10'd575}));
      if (i == 579) chk("pool_start", 64'({relu_we, pool_valid, fc_enable}), 64'({1'b0, 1'b1, 1'b0}));
      if (i == 580) chk("fc_enable_rise", 64'({pool_out_valid, fc_enable}), 64'd3);
      if (i == 724) chk("fc_state", 64'({fc_enable, done, busy}), 64'({1'b1, 1'b0, 1'b1}));
      if (i == 725) chk("done_pulse", 64'({done, result_load, fc_enable}), 64'({1'b1, 1'b1, 1'b0}));
      if (i == 726) chk("idle_after_done", 64'({done, busy, error}), 64'd0);
    end
    start = 1'b0;
    chk("win_count", 64'(wcnt), 64'd576);
    chk("win_first_cycle", 64'(first_wcyc), 64'd1);
    chk("win_first_last", 64'({8'(first_wx), 8'(first_wy), 8'(last_wx), 8'(last_wy)}),
        64'({8'd0, 8'd0, 8'd23, 8'd23}));
    chk("relu_count", 64'(rcnt), 64'd576);
    chk("relu_first_cycle", 64'(first_rcyc), 64'd3);
    chk("relu_addr_and_gaps", 64'(addr_err + gap_err), 64'd0);
    chk("pool_count", 64'(pcnt), 64'd144);
    chk("pool_idx_seq", 64'(pidx_err), 64'd0);
    chk("done_count", 64'(dcnt), 64'd1);
    chk("done_cycle", 64'(dcyc), 64'd725);
    chk("done_with_load", 64'(ld_err), 64'd0);

    // FC timeout: FC occupies cycles 724..4818, error shows in cycle 4819.
    fc_done = 1'b0;
    start_run();
    for (int i = 2; i <= 4822; i++) begin
      tick();
      if (i == 4818) chk("pre_timeout", 64'({error, busy}), 64'({1'b0, 1'b1}));
      if (i == 4819) chk("timeout_error", 64'({error, busy}), 64'({1'b1, 1'b0}));
    end
    chk("timeout_no_done", 64'(dcnt), 64'd0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_keeps_error", 64'(error), 64'd1);

    // Next start clears error; abort in CONV cycle 300.
    start_run();
    chk("start_clears_error", 64'({error, busy}), 64'({1'b0, 1'b1}));
    for (int i = 2; i <= 300; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_to_idle", 64'(all_outs & ~45'(1'b1) << 36), 64'd0);
    chk("abort_idle_regs", 64'({busy, win_valid, relu_we, win_x, win_y, relu_addr}), 64'd0);
    tick();
    chk("abort_pipe_flushed", 64'({relu_we, busy}), 64'd0);

    // Restart after abort, then async reset while in FC.
    start_run();
    chk("restart_window", 64'({win_valid, win_x, win_y}), 64'({1'b1, 5'd0, 5'd0}));
    for (int i = 2; i <= 800; i++) begin
      tick();
      if (i == 3) chk("restart_relu_addr", 64'({relu_we, relu_addr}), 64'({1'b1, 10'd0}));
    end
    chk("restart_relu_stats", 64'({16'(rcnt), 16'(addr_err + gap_err), 16'(wcnt)}),
        64'({16'd576, 16'd0, 16'd576}));
    chk("in_fc_waiting", 64'({busy, fc_enable, done}), 64'({1'b1, 1'b1, 1'b0}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_fc", 64'(all_outs), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("after_reset_idle", 64'(busy), 64'd0);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 64'(busy), 64'd0);
    tick();
    chk("still_idle", 64'({busy, win_valid}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
